// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift the partial remainder
// left by one quotient bit, then keep or restore based on the external subtractor.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  output logic [N-1:0] trial_lo,
  input  logic [N-1:0] diff,
  input  logic         no_borrow,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] quo_next
);

  logic [N:0] shifted_s;
  logic       ge_s;

  // Shifted remainder may carry into bit N; then it always exceeds the divisor.
  always_comb begin
    shifted_s = {rem, quo[N-1]};
    trial_lo  = shifted_s[N-1:0];
    ge_s      = shifted_s[N] | no_borrow;
    if (ge_s) begin
      rem_next = diff;
      quo_next = {quo[N-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[N-1:0];
      quo_next = {quo[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential add/sub/mul/div unit with valid/ready handshakes; mul and div
// iterate N times over magnitudes through one shared N-bit adder/subtractor.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  input  logic         sgn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res_lo,
  output logic [N-1:0] res_hi,
  output logic         carry,
  output logic         dz
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

  state_t        state_r, state_s;
  alu_op_t       op_s, op_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  hi_r, lo_r, opnd_r;
  logic          neg_q_r, neg_r_r;
  logic [N-1:0]  res_lo_r, res_hi_r;
  logic          carry_r, dz_r;

  logic          accept_s, last_s, b_zero_s, iter_s;
  logic          a_neg_s, b_neg_s;
  logic [N-1:0]  a_mag_s, b_mag_s;
  logic [N-1:0]  add_x_s, add_y_s;
  logic          add_sub_s;
  logic [N:0]    add_full_s;
  logic [N-1:0]  trial_lo_s, div_hi_s, div_lo_s;
  logic [N-1:0]  mul_hi_s, mul_lo_s, step_hi_s, step_lo_s;
  logic [2*N-1:0] prod_fix_s;
  logic [N-1:0]  quo_fix_s, rem_fix_s;
  logic          ovf_s;

  assign op_s      = alu_op_t'(op);
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign res_lo    = res_lo_r;
  assign res_hi    = res_hi_r;
  assign carry     = carry_r;
  assign dz        = dz_r;

  // Request decode, operand magnitudes and iteration bookkeeping.
  always_comb begin
    accept_s = in_valid & (state_r == IDLE);
    b_zero_s = (b == '0);
    iter_s   = (op_s == ALU_MUL) | ((op_s == ALU_DIV) & ~b_zero_s);
    last_s   = (cnt_r == CW'(N - 1));
    a_neg_s  = sgn & a[N-1];
    b_neg_s  = sgn & b[N-1];
    a_mag_s  = a_neg_s ? (~a + ONE_N) : a;
    b_mag_s  = b_neg_s ? (~b + ONE_N) : b;
  end

  // The one adder/subtractor: add/sub results in IDLE, partial sums in CALC.
  always_comb begin
    add_x_s   = a;
    add_y_s   = b;
    add_sub_s = (op_s == ALU_SUB);
    case (state_r)
      IDLE: begin
        add_x_s   = a;
        add_y_s   = b;
        add_sub_s = (op_s == ALU_SUB);
      end
      CALC: begin
        add_y_s = opnd_r;
        if (op_r == ALU_MUL) begin
          add_x_s   = hi_r;
          add_sub_s = 1'b0;
        end else begin
          add_x_s   = trial_lo_s;
          add_sub_s = 1'b1;
        end
      end
      default: begin
        add_x_s   = a;
        add_y_s   = b;
        add_sub_s = 1'b0;
      end
    endcase
    add_full_s = {1'b0, add_x_s} + {1'b0, add_y_s ^ {N{add_sub_s}}} + {{N{1'b0}}, add_sub_s};
    if (op_s == ALU_SUB) begin
      ovf_s = (a[N-1] != b[N-1]) & (add_full_s[N-1] != a[N-1]);
    end else begin
      ovf_s = (a[N-1] == b[N-1]) & (add_full_s[N-1] != a[N-1]);
    end
  end

  div_step #(.N(N)) u_div_step (
    .rem       (hi_r),
    .quo       (lo_r),
    .trial_lo  (trial_lo_s),
    .diff      (add_full_s[N-1:0]),
    .no_borrow (add_full_s[N]),
    .rem_next  (div_hi_s),
    .quo_next  (div_lo_s)
  );

  // Shift-add multiply step: {carry, hi+mcand, lo} or {0, hi, lo} shifted right.
  always_comb begin
    if (lo_r[0]) begin
      mul_hi_s = add_full_s[N:1];
      mul_lo_s = {add_full_s[0], lo_r[N-1:1]};
    end else begin
      mul_hi_s = {1'b0, hi_r[N-1:1]};
      mul_lo_s = {hi_r[0], lo_r[N-1:1]};
    end
    if (op_r == ALU_MUL) begin
      step_hi_s = mul_hi_s;
      step_lo_s = mul_lo_s;
    end else begin
      step_hi_s = div_hi_s;
      step_lo_s = div_lo_s;
    end
    prod_fix_s = neg_q_r ? (~{step_hi_s, step_lo_s} + ONE_2N) : {step_hi_s, step_lo_s};
    quo_fix_s  = neg_q_r ? (~step_lo_s + ONE_N) : step_lo_s;
    rem_fix_s  = neg_r_r ? (~step_hi_s + ONE_N) : step_hi_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = iter_s ? CALC : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration registers and result registers (held in DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= ALU_ADD;
      cnt_r    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      opnd_r   <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      res_lo_r <= '0;
      res_hi_r <= '0;
      carry_r  <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r    <= op_s;
            cnt_r   <= '0;
            hi_r    <= '0;
            lo_r    <= a_mag_s;
            opnd_r  <= b_mag_s;
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            if ((op_s == ALU_ADD) || (op_s == ALU_SUB)) begin
              res_lo_r <= add_full_s[N-1:0];
              res_hi_r <= '0;
              carry_r  <= sgn ? ovf_s : add_full_s[N];
              dz_r     <= 1'b0;
            end else if ((op_s == ALU_DIV) && b_zero_s) begin
              res_lo_r <= {N{1'b1}};
              res_hi_r <= a;
              carry_r  <= 1'b0;
              dz_r     <= 1'b1;
            end
          end
        end
        CALC: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            carry_r <= 1'b0;
            dz_r    <= 1'b0;
            if (op_r == ALU_MUL) begin
              res_lo_r <= prod_fix_s[N-1:0];
              res_hi_r <= prod_fix_s[2*N-1:N];
            end else begin
              res_lo_r <= quo_fix_s;
              res_hi_r <= rem_fix_s;
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
